ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction fetch engine on the consumer side of the PC block. Samples the PC address, issues one instruction-memory read at a time over a req/ack handshake, and pulses push back to the PC block so it advances. Returned words are buffered with their fetch address in a small FIFO feeding decode over a valid/ready handshake. A flush input, driven by branch/jump resolution, discards all buffered and in-flight instructions.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction word width
DEPTH, 2, fetch buffer entries; power of 2, range 2..8

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pc_addr  in  ADDR_W  current PC from PC block
pc_push  out  1  one-cycle pulse: PC block advances to next address
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_W  read address, registered
mem_ack  in  1  memory returns mem_rdata this cycle; completes request
mem_rdata  in  DATA_W  instruction word, valid when mem_ack=1
ins_valid  out  1  buffer head holds a valid instruction
ins_data  out  DATA_W  head instruction word
ins_pc  out  ADDR_W  fetch address of head instruction
ins_ready  in  1  decode accepts head this cycle
flush  in  1  discard buffered and in-flight instructions
busy  out  1  high when state is not IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; mem_req=0, mem_addr=0, pc_push=0, count=0, ins_valid=0, ins_data=0, ins_pc=0. Reset during REQ drops mem_req at once; the transaction is abandoned, nothing is written.
- pop = ins_valid & ins_ready & ~flush. wr = (state==REQ) & mem_ack & ~flush. count_next = count + wr - pop. Arithmetic on count is DEPTH-bounded; overflow/underflow is impossible by construction and is an assertion failure in verification.
- issue = ~flush & (count_next < DEPTH).
- FSM states: IDLE, REQ, DRAIN.
- IDLE: if issue, go to REQ; at that edge mem_addr<=pc_addr, mem_req<=1, pc_push<=1.
- REQ: mem_req held 1 and mem_addr held stable until mem_ack is sampled 1.
  - mem_ack & ~flush: push {mem_addr, mem_rdata} into the FIFO. If issue, stay in REQ, capturing a new mem_addr<=pc_addr with pc_push<=1 (back-to-back, one word/cycle sustained). Otherwise mem_req<=0 and go to IDLE.
  - mem_ack & flush: discard word; mem_req<=0; go to IDLE.
  - ~mem_ack & flush: go to DRAIN; mem_req stays 1 and mem_addr stays unchanged.
- DRAIN: wait for mem_ack, discard the returned word, mem_req<=0, go to IDLE. A flush while in DRAIN has no additional effect.
- pc_push is high for exactly one cycle per issued request. It is never high in IDLE or DRAIN, or while reset is high.
- Flush (any state): FIFO pointers and count are cleared at the edge; ins_valid=0 next cycle. The pop in the flush cycle is suppressed.
- After flush, the earliest new request is 1 cycle later from IDLE. From DRAIN, it is 1 cycle after the draining ack.
- FIFO: DEPTH entries, wrap-around pointers. Write and pop in the same cycle are legal when full (count stays DEPTH) and when count=1. ins_data and ins_pc show the head entry and are 0 when empty.
- Ordering: instructions leave in issue order. ins_pc equals the pc_addr sampled at issue.
- Latency: request to ins_valid is 1 cycle after the mem_ack edge.

Test Plan:
1. Reset, pc_addr=0x00000000, mem_ack tied 1, ins_ready=1 -> pc_push once per cycle; ins_pc sequence 0x0, 0x4, 0x8 (PC block increments by 4); ins_valid continuous after 2 cycles.
2. ins_ready=0, mem_ack=1, DEPTH=2 -> exactly 2 fetches, then mem_req=0, count=2, pc_push stays 0. Raise ins_ready -> fetch resumes in the same cycle as the first pop.
3. mem_ack delayed 3 cycles -> mem_req held 1 for 4 cycles, mem_addr stable, pc_push high only in the first REQ cycle.
4. Flush in REQ cycle 2 of a 4-cycle ack wait -> DRAIN entered, the late word (0xDEADBEEF) never appears on ins_data, next mem_addr equals the new pc_addr (0x00000100).
5. Flush coincident with mem_ack and ins_ready with 2 entries buffered -> no pop, no write, ins_valid=0 next cycle, state IDLE.
6. Assert reset while mem_req=1 -> mem_req=0 in the same cycle (before the next edge), all outputs 0; after release, first fetch uses pc_addr=0x0.

Source files
------------

// File: rtl/ifetch_if.sv
// ifetch_if: PC, instruction-memory and decode handshakes of the fetch unit.
interface ifetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_push;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              ins_valid;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_ready;
    logic              flush;
    logic              busy;
    modport master (
        input  pc_addr, mem_ack, mem_rdata, ins_ready, flush,
        output pc_push, mem_req, mem_addr, ins_valid, ins_data, ins_pc, busy
    );
    modport slave (
        output pc_addr, mem_ack, mem_rdata, ins_ready, flush,
        input  pc_push, mem_req, mem_addr, ins_valid, ins_data, ins_pc, busy
    );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: one-outstanding-read fetch engine with a small in-order buffer toward decode.
module ifetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic      clk,
    input  logic      reset,
    ifetch_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t            state_q;
    logic              mem_req_q;
    logic              pc_push_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic              pop;
    logic              wr;
    logic              issue;
    always_comb begin
        pop     = bus.ins_valid & bus.ins_ready & ~bus.flush;
        wr      = (state_q == REQ) & bus.mem_ack & ~bus.flush;
        count_d = count_q + CW'(wr) - CW'(pop);
        issue   = ~bus.flush & (count_d < CW'(DEPTH));
    end
    // a request is only issued when its word is guaranteed a buffer slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            pc_push_q  <= 1'b0;
            mem_addr_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            pc_push_q <= 1'b0;
            wptr_q    <= bus.flush ? '0 : wptr_q + PW'(wr);
            rptr_q    <= bus.flush ? '0 : rptr_q + PW'(pop);
            count_q   <= bus.flush ? '0 : count_d;
            case (state_q)
                IDLE: if (issue) begin
                    state_q    <= REQ;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= bus.pc_addr;
                    pc_push_q  <= 1'b1;
                end
                REQ: if (bus.mem_ack) begin
                    if (issue) begin
                        mem_addr_q <= bus.pc_addr;
                        pc_push_q  <= 1'b1;
                    end else begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end else if (bus.flush) begin
                    state_q <= DRAIN;
                end
                DRAIN: if (bus.mem_ack) begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (wr) begin
            data_q[wptr_q] <= bus.mem_rdata;
            addr_q[wptr_q] <= mem_addr_q;
        end
    end
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.pc_push   = pc_push_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.ins_valid = count_q != '0;
    assign bus.ins_data  = bus.ins_valid ? data_q[rptr_q] : '0;
    assign bus.ins_pc    = bus.ins_valid ? addr_q[rptr_q] : '0;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: PC block and memory models around ifetch_unit with an in-order scoreboard.
module tb_ifetch_unit;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] d;
    } ent_t;
    logic        clk;
    logic        reset;
    logic [31:0] pc_q;
    logic [31:0] exp_next;
    logic [31:0] tgt;
    logic        force_ack;
    logic        poison;
    logic        drain;
    int          lat;
    int          wcnt;
    int          n_chk;
    int          n_pass;
    ent_t        q[$];
    ifetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    ifetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    function automatic logic [31:0] word_of(logic [31:0] a);
        return {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask
    // called at a falling edge; plays memory and PC block for the next rising edge
    task automatic step();
        logic [31:0] npc;
        ent_t e;
        chk("ins_valid", 32'(bus.ins_valid), 32'(q.size() != 0));
        if (!bus.ins_valid) chk("empty_head", bus.ins_pc | bus.ins_data, 0);
        if (bus.ins_valid) chk("no_poison", 32'(bus.ins_data != 32'hDEADBEEF), 1);
        if (!bus.mem_req) chk("push_idle", 32'(bus.pc_push), 0);
        wcnt = (!bus.mem_req || bus.pc_push) ? 0 : wcnt + 1;
        bus.mem_ack   = force_ack | (bus.mem_req && wcnt >= lat);
        bus.mem_rdata = poison ? 32'hDEADBEEF : word_of(bus.mem_addr);
        bus.pc_addr   = pc_q + (bus.pc_push ? 32'd4 : 32'd0);
        if (bus.ins_valid && bus.ins_ready && !bus.flush && q.size() > 0) begin
            e = q.pop_front();
            chk("ins_pc", bus.ins_pc, e.pc);
            chk("ins_data", bus.ins_data, e.d);
        end
        if (bus.mem_req && bus.mem_ack) begin
            if (!drain && !bus.flush) begin
                chk("mem_addr", bus.mem_addr, exp_next);
                q.push_back('{pc: exp_next, d: word_of(exp_next)});
                exp_next += 4;
            end
            drain = 1'b0;
        end else if (bus.mem_req && bus.flush) begin
            drain = 1'b1;
        end
        if (bus.flush) begin
            q.delete();
            exp_next = tgt;
        end
        chk("depth", 32'(q.size() <= 2), 1);
        npc = bus.flush ? tgt : bus.pc_addr;
        @(posedge clk);
        pc_q = npc;
        @(negedge clk);
    endtask
    task automatic wait_push(string tag);
        for (int i = 0; i < 20 && !bus.pc_push; i++) step();
        chk(tag, 32'(bus.pc_push), 1);
    endtask
    task automatic do_reset();
        bus.mem_ack = 1'b0;
        bus.flush   = 1'b0;
        reset       = 1'b1;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_pc_push", 32'(bus.pc_push), 0);
        chk("rst_ins_valid", 32'(bus.ins_valid), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_ins_pc", bus.ins_pc, 0);
        chk("rst_ins_data", bus.ins_data, 0);
        chk("rst_busy", 32'(bus.busy), 0);
        repeat (2) @(negedge clk);
        q.delete();
        pc_q        = '0;
        bus.pc_addr = '0;
        exp_next    = '0;
        drain       = 1'b0;
        wcnt        = 0;
        reset       = 1'b0;
    endtask
    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1'b0; force_ack = 1'b0; poison = 1'b0; drain = 1'b0;
        lat = 0; wcnt = 0; pc_q = '0; exp_next = '0; tgt = '0;
        bus.pc_addr = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        bus.ins_ready = 1'b0; bus.flush = 1'b0;
        #2;
        do_reset();
        // streaming with immediate acks
        bus.ins_ready = 1'b1;
        wait_push("t1_first");
        for (int i = 0; i < 6; i++) begin
            chk("t1_push", 32'(bus.pc_push), 1);
            step();
        end
        // backpressure fills the buffer and stops fetching
        bus.ins_ready = 1'b0;
        repeat (4) step();
        chk("t2_req", 32'(bus.mem_req), 0);
        chk("t2_push", 32'(bus.pc_push), 0);
        chk("t2_valid", 32'(bus.ins_valid), 1);
        bus.ins_ready = 1'b1;
        step();
        chk("t2_resume_push", 32'(bus.pc_push), 1);
        chk("t2_resume_req", 32'(bus.mem_req), 1);
        // slow memory: request held stable until acked
        lat = 3;
        for (int i = 0; i < 4; i++) begin
            chk("t3_req", 32'(bus.mem_req), 1);
            chk("t3_addr", bus.mem_addr, exp_next);
            chk("t3_push", 32'(bus.pc_push), 32'(i == 0));
            step();
        end
        chk("t3_next_push", 32'(bus.pc_push), 1);
        // flush in the second wait cycle drains the late word
        step();
        bus.flush = 1'b1; tgt = 32'h100; poison = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("t4_busy", 32'(bus.busy), 1);
        chk("t4_req", 32'(bus.mem_req), 1);
        chk("t4_push", 32'(bus.pc_push), 0);
        for (int i = 0; i < 10 && bus.mem_req; i++) step();
        chk("t4_drained", 32'(bus.mem_req), 0);
        poison = 1'b0;
        step();
        chk("t4_push_after", 32'(bus.pc_push), 1);
        chk("t4_addr", bus.mem_addr, 32'h100);
        // flush with a full buffer and a stray ack
        lat = 0; bus.ins_ready = 1'b0;
        repeat (4) step();
        chk("t5_full_req", 32'(bus.mem_req), 0);
        chk("t5_full_valid", 32'(bus.ins_valid), 1);
        bus.flush = 1'b1; force_ack = 1'b1; bus.ins_ready = 1'b1; tgt = 32'h200;
        step();
        bus.flush = 1'b0; force_ack = 1'b0;
        chk("t5_valid", 32'(bus.ins_valid), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_push", 32'(bus.pc_push), 0);
        step();
        chk("t5_push_after", 32'(bus.pc_push), 1);
        chk("t5_addr", bus.mem_addr, 32'h200);
        // flush coincident with an ack while streaming
        repeat (3) step();
        bus.flush = 1'b1; tgt = 32'h300;
        step();
        bus.flush = 1'b0;
        chk("t5b_req", 32'(bus.mem_req), 0);
        chk("t5b_busy", 32'(bus.busy), 0);
        chk("t5b_valid", 32'(bus.ins_valid), 0);
        wait_push("t5b_push");
        chk("t5b_addr", bus.mem_addr, 32'h300);
        // reset in the middle of a request
        lat = 3;
        step();
        chk("t6_pre_req", 32'(bus.mem_req), 1);
        do_reset();
        lat = 0;
        wait_push("t6_push");
        chk("t6_addr", bus.mem_addr, 0);
        repeat (4) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
